// File: rtl/control_sequencer.sv
// control_sequencer: microcoded-style control FSM for a small 8-bit accumulator CPU.
// Steps T0..T4 fetch and execute one instruction; HLT parks the FSM in HALTED until rst.
// All control outputs are decoded combinationally from the current state, the opcode and
// the latched ALU flags, so reset forces them to their T0 values immediately.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opcode          instruction register upper nibble (ir[7:4])
//   c_in, z_in      ALU carry / zero, latched into cf / zf when flags_load=1
//   pc_out, ir_out, ram_out, a_out, alu_enable         bus drivers (at most one active)
//   mar_load, ir_load, a_load, b_load, ram_in, pc_load, out_load, flags_load   loads
//   sub, inc_a, dec_a                                  ALU operation select
//   pc_inc          program counter increment
//   halt            high while HALTED
//   step            current state encoding
//   cf, zf          latched carry / zero flags
module control_sequencer #(
   parameter int unsigned OPW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           c_in,
   input  logic           z_in,
   output logic           pc_out,
   output logic           ir_out,
   output logic           ram_out,
   output logic           a_out,
   output logic           alu_enable,
   output logic           mar_load,
   output logic           ir_load,
   output logic           a_load,
   output logic           b_load,
   output logic           ram_in,
   output logic           pc_load,
   output logic           out_load,
   output logic           flags_load,
   output logic           sub,
   output logic           inc_a,
   output logic           dec_a,
   output logic           pc_inc,
   output logic           halt,
   output logic [2:0]     step,
   output logic           cf,
   output logic           zf
);

   typedef enum logic [2:0] {
      StT0   = 3'd0,
      StT1   = 3'd1,
      StT2   = 3'd2,
      StT3   = 3'd3,
      StT4   = 3'd4,
      StHalt = 3'd7
   } state_e;

   localparam logic [3:0] OpLda = 4'h0;
   localparam logic [3:0] OpAdd = 4'h1;
   localparam logic [3:0] OpSub = 4'h2;
   localparam logic [3:0] OpSta = 4'h3;
   localparam logic [3:0] OpLdi = 4'h4;
   localparam logic [3:0] OpJmp = 4'h5;
   localparam logic [3:0] OpJc  = 4'h6;
   localparam logic [3:0] OpJz  = 4'h7;
   localparam logic [3:0] OpInc = 4'h8;
   localparam logic [3:0] OpDec = 4'h9;
   localparam logic [3:0] OpOut = 4'hE;
   localparam logic [3:0] OpHlt = 4'hF;

   state_e     state_q, state_d;
   logic       cf_q, zf_q;
   logic [3:0] op;

   // Decoding is defined on a 4-bit opcode; other widths are resized to it.
   assign op = 4'(opcode);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StT0;
         cf_q    <= 1'b0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (flags_load) begin
            cf_q <= c_in;
            zf_q <= z_in;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_out     = 1'b0;
      ir_out     = 1'b0;
      ram_out    = 1'b0;
      a_out      = 1'b0;
      alu_enable = 1'b0;
      mar_load   = 1'b0;
      ir_load    = 1'b0;
      a_load     = 1'b0;
      b_load     = 1'b0;
      ram_in     = 1'b0;
      pc_load    = 1'b0;
      out_load   = 1'b0;
      flags_load = 1'b0;
      sub        = 1'b0;
      inc_a      = 1'b0;
      dec_a      = 1'b0;
      pc_inc     = 1'b0;
      halt       = 1'b0;

      unique case (state_q)
         StT0: begin
            pc_out   = 1'b1;
            mar_load = 1'b1;
            state_d  = StT1;
         end
         StT1: begin
            ram_out = 1'b1;
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = StT2;
         end
         StT2: begin
            state_d = StT0;
            case (op)
               OpLda, OpAdd, OpSub, OpSta: begin
                  ir_out   = 1'b1;
                  mar_load = 1'b1;
                  state_d  = StT3;
               end
               OpLdi: begin
                  ir_out = 1'b1;
                  a_load = 1'b1;
               end
               OpJmp: begin
                  ir_out  = 1'b1;
                  pc_load = 1'b1;
               end
               OpJc: begin
                  ir_out  = cf_q;
                  pc_load = cf_q;
               end
               OpJz: begin
                  ir_out  = zf_q;
                  pc_load = zf_q;
               end
               OpInc: begin
                  inc_a      = 1'b1;
                  alu_enable = 1'b1;
                  a_load     = 1'b1;
                  flags_load = 1'b1;
               end
               OpDec: begin
                  dec_a      = 1'b1;
                  alu_enable = 1'b1;
                  a_load     = 1'b1;
                  flags_load = 1'b1;
               end
               OpOut: begin
                  a_out    = 1'b1;
                  out_load = 1'b1;
               end
               OpHlt: state_d = StHalt;
               default: ;  // A..D are NOPs
            endcase
         end
         StT3: begin
            state_d = StT0;
            case (op)
               OpLda: begin
                  ram_out = 1'b1;
                  a_load  = 1'b1;
               end
               OpAdd, OpSub: begin
                  ram_out = 1'b1;
                  b_load  = 1'b1;
                  state_d = StT4;
               end
               OpSta: begin
                  a_out  = 1'b1;
                  ram_in = 1'b1;
               end
               default: ;  // opcode changed after T2; nothing to do
            endcase
         end
         StT4: begin
            alu_enable = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            sub        = (op == OpSub);
            state_d    = StT0;
         end
         StHalt: begin
            halt    = 1'b1;
            state_d = StHalt;
         end
         default: state_d = StT0;  // unused codes 5,6 recover to fetch
      endcase
   end

   assign step = state_q;
   assign cf   = cf_q;
   assign zf   = zf_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer plus a random opcode stream checked against a
// small step model and the bus / ALU / flag-load exclusivity rules.
module tb_control_sequencer;

   localparam int unsigned OPW = 4;

   // Control vector bit masks, in the order packed into ctrl below.
   localparam logic [17:0] M_PC_OUT   = 18'b1 << 17;
   localparam logic [17:0] M_IR_OUT   = 18'b1 << 16;
   localparam logic [17:0] M_RAM_OUT  = 18'b1 << 15;
   localparam logic [17:0] M_A_OUT    = 18'b1 << 14;
   localparam logic [17:0] M_ALU_EN   = 18'b1 << 13;
   localparam logic [17:0] M_MAR_LD   = 18'b1 << 12;
   localparam logic [17:0] M_IR_LD    = 18'b1 << 11;
   localparam logic [17:0] M_A_LD     = 18'b1 << 10;
   localparam logic [17:0] M_B_LD     = 18'b1 << 9;
   localparam logic [17:0] M_RAM_IN   = 18'b1 << 8;
   localparam logic [17:0] M_PC_LD    = 18'b1 << 7;
   localparam logic [17:0] M_OUT_LD   = 18'b1 << 6;
   localparam logic [17:0] M_FLAGS_LD = 18'b1 << 5;
   localparam logic [17:0] M_SUB      = 18'b1 << 4;
   localparam logic [17:0] M_INC_A    = 18'b1 << 3;
   localparam logic [17:0] M_DEC_A    = 18'b1 << 2;
   localparam logic [17:0] M_PC_INC   = 18'b1 << 1;
   localparam logic [17:0] M_HALT     = 18'b1;

   localparam logic [17:0] M_T0  = M_PC_OUT | M_MAR_LD;
   localparam logic [17:0] M_T1  = M_RAM_OUT | M_IR_LD | M_PC_INC;
   localparam logic [17:0] M_ADR = M_IR_OUT | M_MAR_LD;
   localparam logic [17:0] M_JMP = M_IR_OUT | M_PC_LD;
   localparam logic [17:0] M_ALU = M_ALU_EN | M_A_LD | M_FLAGS_LD;

   logic           clk = 1'b0;
   logic           rst;
   logic [OPW-1:0] opcode;
   logic           c_in, z_in;
   logic           pc_out, ir_out, ram_out, a_out, alu_enable;
   logic           mar_load, ir_load, a_load, b_load, ram_in, pc_load, out_load, flags_load;
   logic           sub, inc_a, dec_a, pc_inc, halt;
   logic [2:0]     step;
   logic           cf, zf;
   logic [17:0]    ctrl;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   control_sequencer #(
      .OPW(OPW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .c_in       (c_in),
      .z_in       (z_in),
      .pc_out     (pc_out),
      .ir_out     (ir_out),
      .ram_out    (ram_out),
      .a_out      (a_out),
      .alu_enable (alu_enable),
      .mar_load   (mar_load),
      .ir_load    (ir_load),
      .a_load     (a_load),
      .b_load     (b_load),
      .ram_in     (ram_in),
      .pc_load    (pc_load),
      .out_load   (out_load),
      .flags_load (flags_load),
      .sub        (sub),
      .inc_a      (inc_a),
      .dec_a      (dec_a),
      .pc_inc     (pc_inc),
      .halt       (halt),
      .step       (step),
      .cf         (cf),
      .zf         (zf)
   );

   assign ctrl = {pc_out, ir_out, ram_out, a_out, alu_enable, mar_load, ir_load, a_load,
                  b_load, ram_in, pc_load, out_load, flags_load, sub, inc_a, dec_a, pc_inc,
                  halt};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Check step and controls at mid-cycle, then advance to the next falling edge.
   task automatic cyc(input string tag, input logic [2:0] exp_step, input logic [17:0] exp_ctrl);
      check({tag, " step"}, 32'(step), 32'(exp_step));
      check({tag, " ctrl"}, 32'(ctrl), 32'(exp_ctrl));
      @(negedge clk);
   endtask

   task automatic fetch(input string tag, input logic [3:0] op);
      opcode = OPW'(op);
      cyc({tag, " T0"}, 3'd0, M_T0);
      cyc({tag, " T1"}, 3'd1, M_T1);
   endtask

   task automatic flags(input string tag, input logic ecf, input logic ezf);
      check({tag, " cf"}, 32'(cf), 32'(ecf));
      check({tag, " zf"}, 32'(zf), 32'(ezf));
   endtask

   logic [2:0] mstate;
   logic [3:0] mop;

   initial begin
      rst    = 1'b1;
      opcode = '0;
      c_in   = 1'b0;
      z_in   = 1'b0;

      #2;
      check("reset step", 32'(step), 32'd0);
      check("reset ctrl", 32'(ctrl), 32'(M_T0));
      flags("reset", 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // LDA
      fetch("lda", 4'h0);
      cyc("lda T2", 3'd2, M_ADR);
      cyc("lda T3", 3'd3, M_RAM_OUT | M_A_LD);

      // ADD with carry out
      c_in = 1'b1; z_in = 1'b0;
      fetch("add", 4'h1);
      cyc("add T2", 3'd2, M_ADR);
      cyc("add T3", 3'd3, M_RAM_OUT | M_B_LD);
      cyc("add T4", 3'd4, M_ALU);
      flags("add", 1'b1, 1'b0);

      // JC taken right after ADD
      c_in = 1'b0; z_in = 1'b1;
      fetch("jc1", 4'h6);
      cyc("jc1 T2", 3'd2, M_JMP);
      flags("jc1 hold", 1'b1, 1'b0);

      // SUB setting zero
      c_in = 1'b0; z_in = 1'b1;
      fetch("sub", 4'h2);
      cyc("sub T2", 3'd2, M_ADR);
      cyc("sub T3", 3'd3, M_RAM_OUT | M_B_LD);
      cyc("sub T4", 3'd4, M_ALU | M_SUB);
      flags("sub", 1'b0, 1'b1);

      // JZ taken, JC not taken
      fetch("jz", 4'h7);
      cyc("jz T2", 3'd2, M_JMP);
      fetch("jc0", 4'h6);
      cyc("jc0 T2", 3'd2, '0);

      // STA, LDI, JMP
      fetch("sta", 4'h3);
      cyc("sta T2", 3'd2, M_ADR);
      cyc("sta T3", 3'd3, M_A_OUT | M_RAM_IN);
      fetch("ldi", 4'h4);
      cyc("ldi T2", 3'd2, M_IR_OUT | M_A_LD);
      fetch("jmp", 4'h5);
      cyc("jmp T2", 3'd2, M_JMP);

      // INC / DEC update flags in T2
      c_in = 1'b1; z_in = 1'b0;
      fetch("inc", 4'h8);
      cyc("inc T2", 3'd2, M_ALU | M_INC_A);
      flags("inc", 1'b1, 1'b0);
      c_in = 1'b1; z_in = 1'b1;
      fetch("dec", 4'h9);
      cyc("dec T2", 3'd2, M_ALU | M_DEC_A);
      flags("dec", 1'b1, 1'b1);

      // OUT and NOPs leave flags alone
      c_in = 1'b0; z_in = 1'b0;
      fetch("out", 4'hE);
      cyc("out T2", 3'd2, M_A_OUT | M_OUT_LD);
      fetch("nopa", 4'hA);
      cyc("nopa T2", 3'd2, '0);
      fetch("nopd", 4'hD);
      cyc("nopd T2", 3'd2, '0);
      flags("nop hold", 1'b1, 1'b1);

      // HLT parks the FSM
      fetch("hlt", 4'hF);
      cyc("hlt T2", 3'd2, '0);
      for (int i = 0; i < 20; i++) cyc("halted", 3'd7, M_HALT);
      flags("halted", 1'b1, 1'b1);

      // Reset pulse out of HALTED
      #1 rst = 1'b1;
      #1;
      check("rst halt step", 32'(step), 32'd0);
      check("rst halt ctrl", 32'(ctrl), 32'(M_T0));
      flags("rst halt", 1'b0, 1'b0);
      @(negedge clk);
      opcode = '0;
      rst    = 1'b0;
      fetch("post", 4'h0);
      cyc("post T2", 3'd2, M_ADR);
      cyc("post T3", 3'd3, M_RAM_OUT | M_A_LD);

      // Asynchronous reset during ADD T3
      c_in = 1'b1; z_in = 1'b1;
      fetch("arst", 4'h1);
      cyc("arst T2", 3'd2, M_ADR);
      check("arst T3 step", 32'(step), 32'd3);
      #2 rst = 1'b1;
      #1;
      check("arst step", 32'(step), 32'd0);
      check("arst ctrl", 32'(ctrl), 32'(M_T0));
      flags("arst", 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Random opcode stream (no HLT) against a step model and exclusivity rules
      mstate = 3'd0;
      mop    = 4'h0;
      for (int i = 0; i < 400; i++) begin
         if (mstate == 3'd0) begin
            mop    = 4'($urandom_range(0, 14));
            opcode = OPW'(mop);
         end
         c_in = 1'($urandom);
         z_in = 1'($urandom);
         check("rnd step", 32'(step), 32'(mstate));
         check("rnd bus excl",
               32'($countones({pc_out, ir_out, ram_out, a_out, alu_enable}) <= 1), 32'd1);
         check("rnd alu excl",
               32'(($countones({sub, inc_a, dec_a}) <= 1) &&
                   (({sub, inc_a, dec_a} == 3'b000) || alu_enable)), 32'd1);
         check("rnd flags gate", 32'(!flags_load || alu_enable), 32'd1);
         case (mstate)
            3'd0: mstate = 3'd1;
            3'd1: mstate = 3'd2;
            3'd2: mstate = (mop <= 4'h3) ? 3'd3 : 3'd0;
            3'd3: mstate = (mop == 4'h1 || mop == 4'h2) ? 3'd4 : 3'd0;
            default: mstate = 3'd0;
         endcase
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
